program_loader: RTL and testbench

//  Upstream boot stage for the 4-bit CPU: takes a byte stream with valid/ready handshake and writes 11-bit

---
 rtl/loader_pkg.sv | 19 +
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 180 ++++++++++++++++++
 tb/tb_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and default geometry for the program loader: the FSM state
// encoding and the instruction/address widths of the CPU program RAM.
package loader_pkg;

  localparam int DATA_W = 11;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_CHK,
    ST_RST,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Bus bundles for the program loader: the incoming byte stream (valid/ready)
// and the CPU program-RAM write port.
interface byte_stream_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface ram_wr_if #(
  parameter int DATA_W = loader_pkg::DATA_W,
  parameter int ADDR_W = loader_pkg::ADDR_W
);
  logic [DATA_W-1:0] ram_wr_data;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic              ram_wr_en;

  modport master (output ram_wr_data, output ram_wr_addr, output ram_wr_en);
  modport slave  (input  ram_wr_data, input  ram_wr_addr, input  ram_wr_en);
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs byte pairs into instructions, writes them into the CPU
// program RAM, pulses CPU reset, then runs. Optional checksum: LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = loader_pkg::DATA_W,
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int DEPTH  = loader_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          halt,
  byte_stream_if.slave  in_s,
  ram_wr_if.master      ram_m,
  output logic          cpu_reset,
  output logic          pc_enable,
  output logic          busy,
  output logic          load_done,
  output logic          err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        lo_q, lo_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              pc_enable_q, pc_enable_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              hs;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  // in_ready_q always mirrors the current state, so it is the handshake qualifier.
  assign hs = in_s.in_valid & in_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif

    if (halt) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_d = ST_LO;
            cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
        ST_LO: begin
          if (hs) begin
            lo_d    = in_s.in_data;
            state_d = ST_HI;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + in_s.in_data;
`endif
          end
        end
        ST_HI: begin
          if (hs) begin
            wr_en_d   = 1'b1;
            wr_data_d = DATA_W'({in_s.in_data[2:0], lo_q});
            wr_addr_d = cnt_q;
`ifdef LOADER_CHECKSUM_EN
            sum_d     = sum_q + in_s.in_data;
`endif
            if (cnt_q == LAST_ADDR) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_RST;
`endif
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ST_LO;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (hs) begin
            state_d = (8'(sum_q + in_s.in_data) == 8'h00) ? ST_RST : ST_ERR;
          end
        end
        ST_ERR: begin
          if (load_start) begin
            state_d = ST_LO;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
`endif
        ST_RST:  state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    // Moore outputs are decoded from the next state so they register alongside it.
    in_ready_d  = (state_d == ST_LO) || (state_d == ST_HI) || (state_d == ST_CHK);
    busy_d      = in_ready_d || (state_d == ST_RST);
    cpu_reset_d = (state_d == ST_RST);
    pc_enable_d = (state_d == ST_RUN);
    load_done_d = (state_d == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
    err_d       = (state_d == ST_ERR);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lo_q        <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
      pc_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      pc_enable_q <= pc_enable_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_s.in_ready     = in_ready_q;
  assign ram_m.ram_wr_data = wr_data_q;
  assign ram_m.ram_wr_addr = wr_addr_q;
  assign ram_m.ram_wr_en   = wr_en_q;
  assign cpu_reset         = cpu_reset_q;
  assign pc_enable         = pc_enable_q;
  assign busy              = busy_q;
  assign load_done         = load_done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err               = err_q;
`else
  assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver predicts RAM writes and the
// CPU reset pulse from the image it sends; a negedge monitor checks them in order.
module tb_program_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic reset, load_start, halt;
  logic cpu_reset, pc_enable, busy, load_done, err;

  always #5 clk = ~clk;

  byte_stream_if s_if ();
  ram_wr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) r_if ();

  program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .halt       (halt),
    .in_s       (s_if),
    .ram_m      (r_if),
    .cpu_reset  (cpu_reset),
    .pc_enable  (pc_enable),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err)
  );

  typedef struct {
    bit          is_rst;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [10:0] exp_ram [DEPTH];
  logic [10:0] cpu_ram [DEPTH];
  logic [10:0] img     [DEPTH];
  logic [7:0]  csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: the CPU RAM stand-in is written from DUT outputs; events are popped in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (r_if.ram_wr_en === 1'b1) begin
        cpu_ram[r_if.ram_wr_addr] = r_if.ram_wr_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          check("wr_kind", {31'd0, ev.is_rst}, 32'd0);
          check("wr_addr", 32'(r_if.ram_wr_addr), ev.addr);
          check("wr_data", 32'(r_if.ram_wr_data), ev.data);
          $display("write addr=%0d data=%03h", r_if.ram_wr_addr, r_if.ram_wr_data);
        end
      end
      if (cpu_reset === 1'b1) begin
        check("pc_en_in_rst", 32'(pc_enable), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_cpu_reset", 32'd1, 32'd0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          check("rst_kind", {31'd0, ev.is_rst}, 32'd1);
          $display("cpu_reset pulse");
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  g;
    bit  ok;
    g  = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    ok = 1'b0;
    s_if.in_valid = 1'b0;
    repeat (g) begin
      s_if.in_data = 8'($urandom);
      step();
    end
    s_if.in_valid = 1'b1;
    s_if.in_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_if.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    s_if.in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Word k is split into a low byte and a high byte whose bits [7:3] are random junk.
  task automatic send_word(input int k, input int max_gap, input bit poke_start);
    logic [7:0] lo, hi;
    ev_t        ev;
    lo = img[k][7:0];
    hi = {5'($urandom), img[k][10:8]};
    csum = csum + lo + hi;
    send_byte(lo, max_gap);
    if (poke_start) pulse_start();
    ev.is_rst = 1'b0;
    ev.addr   = 32'(k);
    ev.data   = 32'(img[k]);
    exp_q.push_back(ev);
    exp_ram[k] = img[k];
    send_byte(hi, max_gap);
  endtask

  task automatic load_image(input int n_words, input int max_gap, input int poke_word, input bit bad_trailer);
    ev_t ev;
    csum = 8'h00;
    pulse_start();
    for (int k = 0; k < n_words; k++) send_word(k, max_gap, k == poke_word);
    if (n_words == DEPTH) begin
`ifdef LOADER_CHECKSUM_EN
      if (!bad_trailer) begin
        ev.is_rst = 1'b1; ev.addr = 0; ev.data = 0;
        exp_q.push_back(ev);
      end
      send_byte(8'(8'h00 - csum) + (bad_trailer ? 8'h01 : 8'h00), max_gap);
`else
      if (!bad_trailer) begin
        ev.is_rst = 1'b1; ev.addr = 0; ev.data = 0;
        exp_q.push_back(ev);
      end
`endif
    end
  endtask

  task automatic wait_run(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_run_timeout"}, {31'd0, ok}, 32'd1);
    check({name, "_pc_enable"}, 32'(pc_enable), 32'd1);
    check({name, "_load_done"}, 32'(load_done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_in_ready"}, 32'(s_if.in_ready), 32'd0);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    $display("%s: running, pc_enable=%0b load_done=%0b", name, pc_enable, load_done);
  endtask

  task automatic check_ram(input string name);
    for (int i = 0; i < DEPTH; i++) check({name, "_ram"}, 32'(cpu_ram[i]), 32'(exp_ram[i]));
  endtask

  task automatic do_halt(input string name);
    halt = 1'b1;
    step();
    halt = 1'b0;
    @(negedge clk);
    check({name, "_halt_pc_enable"}, 32'(pc_enable), 32'd0);
    check({name, "_halt_in_ready"}, 32'(s_if.in_ready), 32'd0);
    check({name, "_halt_busy"}, 32'(busy), 32'd0);
    check({name, "_halt_load_done"}, 32'(load_done), 32'd0);
    $display("%s: halted, pc_enable=%0b in_ready=%0b", name, pc_enable, s_if.in_ready);
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; halt = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = 8'h00;
    csum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      exp_ram[i] = '0;
      cpu_ram[i] = '0;
    end
    repeat (3) step();
    reset = 1'b0;

    // Reset state after 5 idle cycles
    repeat (5) step();
    @(negedge clk);
    check("rst_in_ready", 32'(s_if.in_ready), 32'd0);
    check("rst_wr_en", 32'(r_if.ram_wr_en), 32'd0);
    check("rst_wr_data", 32'(r_if.ram_wr_data), 32'd0);
    check("rst_wr_addr", 32'(r_if.ram_wr_addr), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_pc_enable", 32'(pc_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    $display("reset: outputs idle");

    // Fixed image, no gaps
    for (int k = 0; k < DEPTH; k++) img[k] = 11'h400 | 11'(k);
    step();
    load_image(DEPTH, 0, -1, 1'b0);
    wait_run("fixed");
    check("fixed_ram7", 32'(cpu_ram[7]), 32'h407);
    check_ram("fixed");

    // load_start during RUN is ignored
    pulse_start();
    repeat (5) @(negedge clk);
    check("run_start_load_done", 32'(load_done), 32'd1);
    check("run_start_pc_enable", 32'(pc_enable), 32'd1);
    check("run_start_busy", 32'(busy), 32'd0);
    do_halt("run");

    // Same image with random gaps, plus a load_start poke while in HI
    load_image(DEPTH, 3, 4, 1'b0);
    wait_run("gappy");
    check_ram("gappy");
    do_halt("gappy");

    // Random images with random gaps
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < DEPTH; k++) img[k] = 11'($urandom);
      load_image(DEPTH, 2, -1, 1'b0);
      wait_run("random");
      check_ram("random");
      do_halt("random");
    end

    // Halt after 3 words: rows 0..2 updated, 3..7 keep previous contents
    for (int k = 0; k < DEPTH; k++) img[k] = 11'($urandom);
    load_image(3, 1, -1, 1'b0);
    do_halt("abort");
    repeat (2) @(negedge clk);
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    check_ram("abort");

    // A new load after the abort starts again from address 0
    for (int k = 0; k < DEPTH; k++) img[k] = 11'($urandom);
    step();
    load_image(DEPTH, 1, -1, 1'b0);
    wait_run("reload");
    check_ram("reload");
    do_halt("reload");

`ifdef LOADER_CHECKSUM_EN
    // Bad trailer goes to ERR; a good image afterwards recovers to RUN
    for (int k = 0; k < DEPTH; k++) img[k] = 11'($urandom);
    load_image(DEPTH, 1, -1, 1'b1);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (err === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      check("bad_err_timeout", {31'd0, ok}, 32'd1);
    end
    repeat (3) @(negedge clk);
    check("bad_err", 32'(err), 32'd1);
    check("bad_pc_enable", 32'(pc_enable), 32'd0);
    check("bad_load_done", 32'(load_done), 32'd0);
    $display("checksum: bad trailer, err=%0b", err);
    step();
    for (int k = 0; k < DEPTH; k++) img[k] = 11'($urandom);
    load_image(DEPTH, 1, -1, 1'b0);
    wait_run("recover");
    check_ram("recover");
`endif

    repeat (3) step();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute safety net so the run always terminates
  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "global timeout");
  end

endmodule
